// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: fetches from a one-cycle-latency ROM into a small FIFO
// that feeds decode, with branch redirect handling (optional single delay slot).
module inst_prefetch_queue #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                rom_data_i,
    output logic                       rom_ce_o,
    output logic [31:0]                rom_addr_o,
    input  logic                       id_ready_i,
    output logic                       id_valid_o,
    output logic [31:0]                id_pc_o,
    output logic [31:0]                id_inst_o,
    input  logic                       branch_flag_i,
    input  logic [31:0]                branch_target_address_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [31:0]   fetch_pc;

    logic [PW-1:0] head_n, tail_n;
    logic [CW-1:0] count_n;
    logic          inflight_n;
    logic [31:0]   inflight_pc_n;
    logic [31:0]   fetch_pc_n;

    logic          pop;
    logic          push;
    logic          issue;
    logic          redirect;
    logic          keep_entry;
    logic          slot_inflight;
    logic          slot_issue;
    logic          has_space;
    logic [CW:0]   occupancy;

    assign id_valid_o = (count != '0);
    assign id_pc_o    = id_valid_o ? pc_mem[head]   : 32'h0;
    assign id_inst_o  = id_valid_o ? inst_mem[head] : 32'h0;
    assign count_o    = count;
    assign rom_addr_o = fetch_pc;
    assign rom_ce_o   = issue;

    assign pop      = id_valid_o & id_ready_i;
    assign redirect = pop & branch_flag_i;

    // Delay-slot selection: an entry still queued behind the branch wins, then a
    // response already on its way, otherwise the slot is fetched right now.
    assign keep_entry    = DELAY_SLOT && (count > CW'(1));
    assign slot_inflight = DELAY_SLOT && !keep_entry && inflight;
    assign slot_issue    = DELAY_SLOT && !keep_entry && !inflight;

    // Entries already owned (queued + outstanding) must leave room for one more.
    always_comb begin
        occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
        has_space = occupancy < (CW+1)'(DEPTH);
    end

    always_comb begin
        issue = 1'b0;
        if (!rst) begin
            if (redirect) begin
                issue = slot_issue;
            end else begin
                issue = has_space;
            end
        end
    end

    assign push = inflight & (!redirect | slot_inflight);

    always_comb begin
        head_n  = head + PW'(pop);
        tail_n  = tail + PW'(push);
        count_n = count + CW'(push) - CW'(pop);
        if (redirect) begin
            if (!DELAY_SLOT) begin
                head_n  = '0;
                tail_n  = '0;
                count_n = '0;
            end else if (keep_entry) begin
                // Drop everything younger than the entry right behind the branch.
                head_n  = head + PW'(1);
                tail_n  = head + PW'(2);
                count_n = CW'(1);
            end else if (slot_issue) begin
                head_n  = '0;
                tail_n  = '0;
                count_n = '0;
            end
        end
    end

    always_comb begin
        inflight_n    = issue;
        inflight_pc_n = issue ? fetch_pc : inflight_pc;
        fetch_pc_n    = fetch_pc;
        if (redirect) begin
            fetch_pc_n = branch_target_address_i;
        end else if (issue) begin
            fetch_pc_n = fetch_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            fetch_pc    <= RESET_PC;
        end else begin
            head        <= head_n;
            tail        <= tail_n;
            count       <= count_n;
            inflight    <= inflight_n;
            inflight_pc <= inflight_pc_n;
            fetch_pc    <= fetch_pc_n;
        end
    end

    // Storage is never read unless count says so, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]   <= inflight_pc;
            inst_mem[tail] <= rom_data_i;
        end
    end

endmodule
